// File: rtl/arb4_rr_sel_if.sv
// -----------------------------------------------------------------------------
// arb4_rr_sel_if
// Request/grant bundle between four requesters and the round-robin arbiter
// that drives the select of the shared 4:1 data mux.
//   req     : per-requester request, bit i belongs to requester i
//   gnt     : registered one-hot (or zero) grant
//   sel     : encoded owner index, wired straight to the mux select
//   busy    : high while any grant is active
//   preempt : one-cycle pulse on the first cycle of a preempting grant
// Modports:
//   master : requester side (drives req, observes the arbiter outputs)
//   slave  : arbiter side (samples req, drives gnt/sel/busy/preempt)
// -----------------------------------------------------------------------------
interface arb4_rr_sel_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy,
    output preempt
  );
endinterface

// File: rtl/arb4_rr_sel.sv
// -----------------------------------------------------------------------------
// arb4_rr_sel
// Four-way round-robin arbiter for a shared resource. Grants are registered
// and held while the owner keeps requesting. On release the next requester
// in rotating order (starting after the releasing owner) is granted in the
// same edge, so ownership changes with no idle cycle.
//
// Optional feature, enabled by defining ARB_HOLD_LIMIT_EN:
//   an 8-bit hold counter preempts an owner after MAX_HOLD consecutive grant
//   cycles when another requester is waiting; preempt pulses for one cycle.
//   Without the macro the counter is not built and preempt is tied low.
//
// Parameters:
//   MAX_HOLD : grant cycles before preemption (2..255), hold-limit build only
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arb4_rr_sel_if.slave (req in; gnt, sel, busy, preempt out)
// All outputs are registers; no combinational path from req to any output.
// -----------------------------------------------------------------------------
module arb4_rr_sel #(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  arb4_rr_sel_if.slave  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb4_rr_sel: MAX_HOLD must be within 2..255");
  end

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_last,  w_last_nxt;
  logic [1:0] r_sel,   w_sel_nxt;
  logic [3:0] r_gnt,   w_gnt_nxt;
  logic       r_busy;
  logic [3:0] w_others;
  logic [1:0] w_win_idle;
  logic [1:0] w_win_rot;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_preempt, w_preempt_nxt;
`endif

  // Highest-priority asserted bit in the order base+1, base+2, base+3, base.
  // Walks from lowest to highest priority so the last hit wins.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] req,
                                           input logic [1:0] base);
    logic [1:0] win;
    logic [1:0] idx;
    win = base;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

  function automatic logic [3:0] f_onehot(input logic [1:0] idx);
    logic [3:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Requests other than the current owner; on release req[owner] is already
  // low, so the same vector serves both release and preemption.
  assign w_others   = bus.req & ~f_onehot(r_owner);
  assign w_win_idle = f_rr_pick(bus.req, r_last);
  assign w_win_rot  = f_rr_pick(w_others, r_owner);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
`ifdef ARB_HOLD_LIMIT_EN
    w_cnt_nxt     = r_cnt;
    w_preempt_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_win_idle;
          w_last_nxt  = w_win_idle;
          w_sel_nxt   = w_win_idle;
          w_gnt_nxt   = f_onehot(w_win_idle);
`ifdef ARB_HOLD_LIMIT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!bus.req[r_owner]) begin
          if (|w_others) begin
            w_owner_nxt = w_win_rot;
            w_last_nxt  = w_win_rot;
            w_sel_nxt   = w_win_rot;
            w_gnt_nxt   = f_onehot(w_win_rot);
`ifdef ARB_HOLD_LIMIT_EN
            w_cnt_nxt   = '0;
`endif
          end else begin
            // sel keeps the last owner so the mux select stays stable
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (r_cnt == HOLD_LAST && |w_others) begin
          w_owner_nxt   = w_win_rot;
          w_last_nxt    = w_win_rot;
          w_sel_nxt     = w_win_rot;
          w_gnt_nxt     = f_onehot(w_win_rot);
          w_cnt_nxt     = '0;
          w_preempt_nxt = 1'b1;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= |w_gnt_nxt;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 8'd0;
      r_preempt <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign bus.preempt = r_preempt;
`else
  assign bus.preempt = 1'b0;
`endif

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_arb4_rr_sel.sv
// -----------------------------------------------------------------------------
// tb_arb4_rr_sel
// Scoreboard bench for arb4_rr_sel. Each cycle the requested pattern is fed
// to a small reference model whose predicted {gnt, sel, busy, preempt} is
// queued; after the following rising edge the DUT outputs are compared with
// the popped entry. A few directed checks cover the asynchronous reset and
// values that must hold across idle periods.
// -----------------------------------------------------------------------------
module tb_arb4_rr_sel;

  localparam int MAX_HOLD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arb4_rr_sel_if bus ();

  arb4_rr_sel #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // reference model state
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_act;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {bus.gnt, bus.sel, bus.busy, bus.preempt};
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int base);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (base + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_last  = 3;
    m_cnt   = 0;
    m_act   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] r);
    bit         pre;
    int         w;
    logic [3:0] g;
    logic [3:0] others;
    pre = 1'b0;
    if (!m_act) begin
      w = rr_pick(r, m_last);
      if (w >= 0) begin
        m_act = 1'b1; m_owner = w; m_last = w; m_cnt = 0;
      end
    end else if (r[m_owner]) begin
`ifdef ARB_HOLD_LIMIT_EN
      others          = r;
      others[m_owner] = 1'b0;
      if (m_cnt == MAX_HOLD - 1 && others != 4'b0000) begin
        w = rr_pick(others, m_owner);
        m_owner = w; m_last = w; m_cnt = 0; pre = 1'b1;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
`else
      others = r;
`endif
    end else begin
      w = rr_pick(r, m_owner);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_cnt = 0;
      end else begin
        m_act = 1'b0;
      end
    end
    g = 4'b0000;
    if (m_act) g[m_owner] = 1'b1;
    exp_q.push_back({g, 2'(m_owner), m_act, pre});
  endtask

  // Drive one request pattern, advance one edge, compare against the model.
  task automatic cycle(input logic [3:0] r, input string tag);
    logic [7:0] e;
    bus.req = r;
    model_step(r);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, obs(), 8'hxx);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs(), e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", obs(), 8'h00);
    rst_n = 1'b1;

    // full contention, each owner drops its own bit for one cycle
    cycle(4'b1111, "rr_first");
    for (int k = 0; k < 4; k++) cycle(4'b1111 & ~(4'b0001 << m_owner), "rr_rotate");
    chk("rr_wrap_gnt", {4'b0000, bus.gnt}, 8'h01);
    cycle(4'b0000, "rr_idle");

    // single requester holds, then releases; sel must stay on its index
    repeat (5) cycle(4'b0100, "hold2");
    cycle(4'b0000, "hold2_rel");
    chk("idle_sel_hold", {6'b0, bus.sel}, 8'h02);
    chk("idle_busy", {7'b0, bus.busy}, 8'h00);

    // owner 2 releases with 1011 pending: next is 3, not 0
    cycle(4'b0100, "own2");
    cycle(4'b1011, "rot_from2");
    chk("rot_from2_gnt", {4'b0000, bus.gnt}, 8'h08);
    cycle(4'b0000, "rot_idle");

    // short pulse on requester 0 while 2 owns is never granted
    cycle(4'b0100, "pulse_own2");
    cycle(4'b0101, "pulse_on");
    cycle(4'b0100, "pulse_off");
    cycle(4'b0000, "pulse_idle");
    chk("pulse_idle_gnt", {4'b0000, bus.gnt}, 8'h00);

    // two continuous requesters: hold limit alternates them when enabled
    repeat (12) cycle(4'b0011, "hold_lim");
    cycle(4'b0000, "hold_lim_rel");

    // asynchronous reset in the middle of a grant to requester 3
    cycle(4'b1000, "own3");
    cycle(4'b1000, "own3_hold");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", obs(), 8'h00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1000, "post_rst");
    cycle(4'b0001, "post_rst_rot");
    cycle(4'b0000, "post_rst_idle");

    // random traffic against the model
    for (int i = 0; i < 60; i++) cycle(4'($urandom_range(0, 15)), "rand");
    cycle(4'b0000, "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb4_rr_sel.md
# arb4_rr_sel

Four-way round-robin arbiter that shares one resource (memory port, write-back bus) between four requesters and drives the 2-bit `sel` of the 4:1 data mux in front of that resource. Grants are registered and held for as long as the owner keeps its request high. An optional hold-limit counter preempts long owners. It sits beside the mux in the pipelined MIPS datapath: `sel` wires directly to the mux select, and `gnt` returns to the requesters.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles before preemption. Range 2..255. Used only with `ARB_HOLD_LIMIT_EN`.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `req` input, 4 bits: request per requester; bit i belongs to requester i.
- `gnt` output, 4 bits: registered grant, one-hot or zero.
- `sel` output, 2 bits: encoded index of the current owner; connects to the mux select.
- `busy` output, 1 bit: high while any grant is active (equals OR of `gnt`).
- `preempt` output, 1 bit: one-cycle pulse in the first cycle of a grant obtained by preemption.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: `owner` holds the resource.
- Internal state: `owner` (2 bits), `last` (2 bits, last owner), hold counter `cnt` (8 bits).
- Priority order is rotating: `last+1`, `last+2`, `last+3`, `last` (mod 4).
- IDLE → GRANT: when any `req` bit is high, pick the highest-priority asserted bit. Set `owner`, set `last` to the winner, clear `cnt`.
- GRANT, `req[owner]`=1: hold the grant and increment `cnt` (saturates at 255).
- GRANT, `req[owner]`=0, release:
  - If other requests are pending, grant the next winner in rotating order from the releasing owner. This gives zero idle cycles between owners.
  - Otherwise go to IDLE.
- `sel` holds the last owner's index in IDLE, so the mux keeps a stable select. Its reset value is 0.
- A request that drops before it is granted is simply not granted. There is no latching of requests.
- A single requester with continuous `req` keeps its grant indefinitely. This holds with the hold limit disabled, and also with it enabled when nobody else is requesting.

## Timing
- Reset values: `gnt`=0000, `sel`=00, `busy`=0, `preempt`=0, state IDLE, `last`=3 (so requester 0 has top priority after reset), `cnt`=0.
- Grant latency: `req` sampled high at edge N gives `gnt` high after edge N, i.e. 1 cycle.
- Release latency: `req[owner]` sampled low at edge N clears `gnt[owner]` after edge N. If a new winner exists, its grant appears in the same cycle.
- `gnt`, `sel`, `busy` and `preempt` are all registers. There are no combinational paths from `req` to any output.
- Simultaneous requests are resolved purely by the rotating order, evaluated at the same edge.
- Reset asserted mid-grant: outputs go to reset values immediately, without waiting for a clock edge. After reset, arbitration restarts with requester 0 at top priority.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined:
  - In GRANT, when `cnt` = `MAX_HOLD`-1, `req[owner]` is still high, and another request is pending, the grant moves at the next edge to the next winner in rotating order.
  - In that first new-grant cycle, `preempt`=1 and `cnt` is cleared.
  - If no other request is pending, the owner keeps the grant and `cnt` saturates.
- `ARB_HOLD_LIMIT_EN` undefined:
  - The counter and preemption logic are not compiled.
  - `preempt` is tied to 0.
  - Grants end only when the owner releases.

## Test plan
- Reset, then `req`=1111 held, with owners releasing after 1 cycle each: grants follow 0,1,2,3,0. `sel` follows 00,01,10,11,00 with no idle cycles; `busy` stays 1.
- `req`=0100 for 5 cycles, then 0000: `gnt`=0100 from cycle 1 to cycle 5 and `sel`=10. Then `gnt`=0000 and `busy`=0, while `sel` stays 10.
- Owner 2 releases while `req`=1011: the next grant goes to 3 (rotating from 2), not to 0.
- `ARB_HOLD_LIMIT_EN` with `MAX_HOLD`=4, `req`=0011 held continuously:
  - 0 is granted for 4 cycles, then 1 is granted with `preempt`=1 for one cycle.
  - 1 is granted for 4 cycles, then 0 is granted again.
  - Without the macro, 0 holds forever.
- `rst_n` pulled low for one cycle mid-grant of requester 3: `gnt`=0000, `sel`=00 and `busy`=0 with no clock edge needed. After release with `req`=1000, requester 3 is granted 1 cycle later.
- `req`=0001 pulsed for one cycle while 2 owns the grant: the pulse is never granted. When 2 releases with `req`=0000, the arbiter returns to IDLE.
